// File: rtl/mem_cmd_sequencer.sv
// Memory command sequencer: runs an optional data phase then an
// instruction fetch on one shared memory port, with init and timeout.
module mem_cmd_sequencer #(
  parameter int INIT_CYCLES = 16,
  parameter int TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  command,
  input  logic [31:0] inst_addr,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic        ready,
  output logic        mem_start_ready,
  output logic [31:0] inst_rdata,
  output logic [31:0] data_rdata,
  output logic [1:0]  error,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  localparam int IW = $clog2(INIT_CYCLES + 1);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_INIT, S_IDLE, S_DATA, S_FETCH
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] init_q, init_d;
  logic [TW-1:0] to_q, to_d;
  logic          start_q, start_d;
  logic          ready_q, valid_q;
  logic [1:0]    error_q, error_d;
  logic [31:0]   inst_q, inst_d;
  logic [31:0]   data_q, data_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [29:0]   iaddr_q, iaddr_d;
  logic          to_hit;
  logic          unused_addr_lsb;

  // Word addressing: the byte offset of either address is irrelevant.
  assign unused_addr_lsb = ^{inst_addr[1:0], data_addr[1:0]};

  assign to_hit = (TIMEOUT != 0) && (to_q == TO_LAST);

  // Next-state and datapath decisions; every register holds by default.
  always_comb begin
    state_d = state_q;
    init_d  = init_q;
    to_d    = to_q;
    start_d = start_q;
    error_d = error_q;
    inst_d  = inst_q;
    data_d  = data_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    iaddr_d = iaddr_q;
    unique case (state_q)
      S_INIT: begin
        if (init_q == INIT_LAST) begin
          state_d = S_IDLE;
          start_d = 1'b1;
        end else begin
          init_d = init_q + IW'(1);
        end
      end
      S_IDLE: begin
        to_d = '0;
        if (command != 3'd0) begin
          wdata_d = data_wdata;
          wstrb_d = data_wstrb;
          iaddr_d = inst_addr[31:2];
          error_d = 2'd0;
          unique case (command)
            3'd1: begin
              state_d = S_FETCH;
              we_d    = 1'b0;
              addr_d  = {inst_addr[31:2], 2'b00};
            end
            3'd2: begin
              if (data_wstrb != 4'd0) begin
                state_d = S_DATA;
                we_d    = 1'b1;
                addr_d  = {data_addr[31:2], 2'b00};
              end else begin
                state_d = S_FETCH;
                we_d    = 1'b0;
                addr_d  = {inst_addr[31:2], 2'b00};
              end
            end
            3'd3: begin
              state_d = S_DATA;
              we_d    = 1'b0;
              addr_d  = {data_addr[31:2], 2'b00};
            end
            default: error_d = 2'd3;
          endcase
        end
      end
      S_DATA: begin
        if (mem_ready) begin
          to_d = '0;
          we_d = 1'b0;
          if (!we_q) data_d = mem_rdata;
          if (mem_err) begin
            state_d = S_IDLE;
            error_d = 2'd1;
          end else begin
            state_d = S_FETCH;
            addr_d  = {iaddr_q, 2'b00};
          end
        end else if (to_hit) begin
          to_d    = '0;
          we_d    = 1'b0;
          state_d = S_IDLE;
          error_d = 2'd2;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      S_FETCH: begin
        if (mem_ready) begin
          to_d    = '0;
          inst_d  = mem_rdata;
          state_d = S_IDLE;
          if (mem_err) error_d = 2'd1;
        end else if (to_hit) begin
          to_d    = '0;
          state_d = S_IDLE;
          error_d = 2'd2;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
    endcase
  end

  // State and output registers; reset drops the request immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      init_q  <= '0;
      to_q    <= '0;
      start_q <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      error_q <= 2'd0;
      inst_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      iaddr_q <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      to_q    <= to_d;
      start_q <= start_d;
      ready_q <= (state_d == S_IDLE);
      valid_q <= (state_d == S_DATA) || (state_d == S_FETCH);
      error_q <= error_d;
      inst_q  <= inst_d;
      data_q  <= data_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      iaddr_q <= iaddr_d;
    end
  end

  assign ready           = ready_q;
  assign mem_start_ready = start_q;
  assign inst_rdata      = inst_q;
  assign data_rdata      = data_q;
  assign error           = error_q;
  assign mem_valid       = valid_q;
  assign mem_we          = we_q;
  assign mem_addr        = addr_q;
  assign mem_wdata       = wdata_q;
  assign mem_wstrb       = wstrb_q;

endmodule

// File: tb/tb_mem_cmd_sequencer.sv
// Bench for mem_cmd_sequencer: vector table plus hand-written
// stall, timeout and mid-transaction reset sequences.
module tb_mem_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  command = '0;
  logic [31:0] inst_addr = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [3:0]  data_wstrb = '0;
  logic        ready, mem_start_ready;
  logic [31:0] inst_rdata, data_rdata;
  logic [1:0]  error;
  logic        mem_valid, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b1;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic [31:0] err_addr = '0;

  int tests = 0;
  int fails = 0;

  mem_cmd_sequencer #(.INIT_CYCLES(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .command(command),
    .inst_addr(inst_addr), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .ready(ready), .mem_start_ready(mem_start_ready),
    .inst_rdata(inst_rdata), .data_rdata(data_rdata),
    .error(error), .mem_valid(mem_valid), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (a == 32'h100) return 32'hAAAA5555;
    if (a == 32'h200) return 32'h12345678;
    return a ^ 32'hC3C30000;
  endfunction

  assign mem_rdata = rd(mem_addr);
  assign mem_err = (err_addr != 0) && mem_valid && (mem_addr == err_addr);

  typedef struct {
    logic [2:0]  cmd;
    logic [31:0] ia, da, wd;
    logic [3:0]  ws;
    logic [31:0] ea;
    int          lat, nreq;
    logic [31:0] a0;
    logic        we0;
    logic [1:0]  err;
    logic [31:0] inst, data;
  } vec_t;

  function automatic vec_t mk(
    input logic [2:0] cmd, input logic [31:0] ia, da, wd,
    input logic [3:0] ws, input logic [31:0] ea,
    input int lat, nreq, input logic [31:0] a0, input logic we0,
    input logic [1:0] err, input logic [31:0] inst, data);
    vec_t v;
    v.cmd = cmd; v.ia = ia; v.da = da; v.wd = wd; v.ws = ws;
    v.ea = ea; v.lat = lat; v.nreq = nreq; v.a0 = a0;
    v.we0 = we0; v.err = err; v.inst = inst; v.data = data;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic count_init(input string name);
    int n = 0;
    int early = 0;
    while (!ready && n < 100) begin
      step();
      n++;
      if (!ready && mem_start_ready) early++;
    end
    chk({name, "_edges"}, n, 16);
    chk({name, "_early_start"}, early, 0);
    chk({name, "_start"}, {31'd0, mem_start_ready}, 1);
  endtask

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nreq;
    logic [31:0] a0, wd0;
    logic we0;
    logic [3:0] ws0;

    vecs[0] = mk(3, 'h200, 'h103, 0, 0, 0, 3, 2, 'h100, 0,
                 0, 'h12345678, 'hAAAA5555);
    vecs[1] = mk(1, 'h307, 'h0, 0, 0, 0, 2, 1, 'h304, 0,
                 0, 'hC3C30304, 'hAAAA5555);
    vecs[2] = mk(2, 'h400, 'h502, 'h11223344, 'hF, 0, 3, 2,
                 'h500, 1, 0, 'hC3C30400, 'hAAAA5555);
    vecs[3] = mk(2, 'h600, 'h700, 'h55, 0, 0, 2, 1, 'h600, 0,
                 0, 'hC3C30600, 'hAAAA5555);
    vecs[4] = mk(3, 'h900, 'h800, 0, 0, 'h800, 2, 1, 'h800, 0,
                 1, 'hC3C30600, 'hC3C30800);
    vecs[5] = mk(5, 'h1000, 'h1100, 0, 0, 0, 1, 0, 0, 0,
                 3, 'hC3C30600, 'hC3C30800);
    vecs[6] = mk(1, 'hA00, 0, 0, 0, 0, 2, 1, 'hA00, 0,
                 0, 'hC3C30A00, 'hC3C30800);
    vecs[7] = mk(3, 'hC00, 'hB00, 0, 0, 'hC00, 3, 2, 'hB00, 0,
                 1, 'hC3C30C00, 'hC3C30B00);
    vecs[8] = mk(7, 'h10, 'h20, 0, 0, 0, 1, 0, 0, 0,
                 3, 'hC3C30C00, 'hC3C30B00);

    #2;
    chk("rst_ready", {31'd0, ready}, 0);
    chk("rst_start", {31'd0, mem_start_ready}, 0);
    chk("rst_valid_we", {30'd0, mem_valid, mem_we}, 0);
    chk("rst_error", {30'd0, error}, 0);
    chk("rst_inst", inst_rdata, 0);
    chk("rst_data", data_rdata, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wstrb", {28'd0, mem_wstrb}, 0);
    step();
    rst_n = 1'b1;
    count_init("init");

    for (int i = 0; i < 9; i++) begin
      command = vecs[i].cmd;
      inst_addr = vecs[i].ia;
      data_addr = vecs[i].da;
      data_wdata = vecs[i].wd;
      data_wstrb = vecs[i].ws;
      err_addr = vecs[i].ea;
      step();
      command = '0;
      lat = 1; nreq = 0;
      a0 = '0; we0 = 1'b0; wd0 = '0; ws0 = '0;
      while (!ready && lat < 50) begin
        if (mem_valid && mem_ready) begin
          if (nreq == 0) begin
            a0 = mem_addr; we0 = mem_we;
            wd0 = mem_wdata; ws0 = mem_wstrb;
          end
          nreq++;
        end
        step();
        lat++;
      end
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_nreq", i), nreq, vecs[i].nreq);
      chk($sformatf("v%0d_error", i), {30'd0, error}, {30'd0, vecs[i].err});
      chk($sformatf("v%0d_inst", i), inst_rdata, vecs[i].inst);
      chk($sformatf("v%0d_data", i), data_rdata, vecs[i].data);
      chk($sformatf("v%0d_valid_idle", i), {31'd0, mem_valid}, 0);
      if (vecs[i].nreq > 0) begin
        chk($sformatf("v%0d_addr0", i), a0, vecs[i].a0);
        chk($sformatf("v%0d_we0", i), {31'd0, we0}, {31'd0, vecs[i].we0});
      end
      if (vecs[i].we0) begin
        chk($sformatf("v%0d_wdata", i), wd0, vecs[i].wd);
        chk($sformatf("v%0d_wstrb", i), {28'd0, ws0}, {28'd0, vecs[i].ws});
      end
      err_addr = '0;
    end

    // write with four stall cycles
    mem_ready = 1'b0;
    command = 3'd2;
    inst_addr = 32'h2000;
    data_addr = 32'h1004;
    data_wdata = 32'hDEADBEEF;
    data_wstrb = 4'h3;
    step();
    command = '0;
    data_wdata = '0;
    data_wstrb = '0;
    lat = 1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("stall%0d_payload", k),
          {mem_valid, mem_we, mem_wstrb, mem_addr[25:0]},
          {1'b1, 1'b1, 4'h3, 26'h1004});
      chk($sformatf("stall%0d_wdata", k), mem_wdata, 32'hDEADBEEF);
      step();
      lat++;
    end
    mem_ready = 1'b1;
    step();
    lat++;
    chk("stall_fetch", {mem_valid, mem_we, mem_addr[29:0]},
        {1'b1, 1'b0, 30'h2000});
    step();
    lat++;
    chk("stall_ready", {31'd0, ready}, 1);
    chk("stall_latency", lat, 7);
    chk("stall_inst", inst_rdata, 32'hC3C32000);

    // timeout on a fetch that never completes
    mem_ready = 1'b0;
    command = 3'd1;
    inst_addr = 32'h3000;
    step();
    command = '0;
    lat = 0;
    while (mem_valid && lat < 50) begin
      lat++;
      step();
    end
    chk("to_valid_cycles", lat, 8);
    chk("to_error", {30'd0, error}, 2);
    chk("to_ready", {31'd0, ready}, 1);
    chk("to_inst_hold", inst_rdata, 32'hC3C32000);

    // asynchronous reset during a fetch
    command = 3'd1;
    inst_addr = 32'h4000;
    step();
    command = '0;
    chk("ar_valid_before", {31'd0, mem_valid}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid_async", {31'd0, mem_valid}, 0);
    chk("ar_start_async", {31'd0, mem_start_ready}, 0);
    chk("ar_inst_cleared", inst_rdata, 0);
    mem_ready = 1'b1;
    step();
    rst_n = 1'b1;
    count_init("reinit");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_cmd_sequencer.md
# mem_cmd_sequencer

Sequences the processor's memory commands onto a single shared memory port. Each accepted command runs an optional data phase (read or write) followed by an instruction fetch, then returns `ready` with the results. The block also produces the post-reset `mem_start_ready` indication and reports bus errors and timeouts on `error`. It sits between the processor core and the single-port memory or bus bridge.

## Interface
- `INIT_CYCLES`, default 16: cycles spent in INIT after reset release before the block reports ready; must be ≥1.
- `TIMEOUT`, default 255: maximum cycles `mem_valid` may wait for `mem_ready`; 0 disables the timeout.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `command` in 3: 0 none, 1 fetch, 2 write+fetch, 3 read+fetch, 4–7 illegal.
- `inst_addr` in 32: fetch address.
- `data_addr` in 32: data address.
- `data_wdata` in 32: write data.
- `data_wstrb` in 4: byte write strobes.
- `ready` out 1: idle and able to accept a command.
- `mem_start_ready` out 1: INIT is complete; sticky until reset.
- `inst_rdata` out 32: last fetched instruction.
- `data_rdata` out 32: last read data word.
- `error` out 2: 0 ok, 1 memory error, 2 timeout, 3 illegal command.
- `mem_valid` out 1: memory request valid.
- `mem_we` out 1: request is a write.
- `mem_addr` out 32: word address, bits [1:0] forced to 0.
- `mem_wdata` out 32: memory write data.
- `mem_wstrb` out 4: memory write strobes.
- `mem_ready` in 1: the transfer completes in the cycle where `mem_valid` and `mem_ready` are both 1.
- `mem_rdata` in 32: read data, valid in the transfer cycle.
- `mem_err` in 1: error flag, sampled in the transfer cycle.

## Operation
- **States:** INIT, IDLE, DATA, FETCH.
- **Reset values:** state=INIT; `ready`=0; `mem_start_ready`=0; `mem_valid`=0; `mem_we`=0; `error`=0; `inst_rdata`=0; `data_rdata`=0; `mem_addr`, `mem_wdata`, `mem_wstrb`=0.
- **INIT:** counts `INIT_CYCLES` cycles, then moves to IDLE and sets `mem_start_ready`=1. `mem_start_ready` is never cleared except by reset.
- **Accepting a command:** `ready`=1 exactly in IDLE. Every rising edge with `ready`=1 and `command`≠0 accepts the command. On acceptance the block latches the addresses, `data_wdata` and `data_wstrb`, and clears `error` to 0. The processor must drive `command`=0 or a new command by the cycle `ready` returns; a held nonzero command is executed again.
- **Command routing:**
  - Command 1 goes to FETCH.
  - Command 2 goes to DATA with `mem_we`=1. If the latched `data_wstrb`=0, the data phase is skipped and the block goes straight to FETCH.
  - Command 3 goes to DATA with `mem_we`=0.
  - Commands 4–7: the block stays in IDLE and sets `error`=3; no memory access is made.
- **DATA:**
  - `mem_valid`=1 with `mem_addr`={data_addr[31:2],2'b00}.
  - Payload is held stable until transfer.
  - On a read transfer, `data_rdata` is loaded from `mem_rdata`.
  - After transfer with `mem_err`=0, go to FETCH.
  - After transfer with `mem_err`=1, set `error`=1, skip the fetch and return to IDLE.
- **FETCH:**
  - `mem_valid`=1, `mem_we`=0, `mem_addr`={inst_addr[31:2],2'b00}.
  - On transfer, `inst_rdata` is loaded from `mem_rdata`.
  - If `mem_err`=1 at transfer, set `error`=1 and still load `inst_rdata`.
  - Then go to IDLE.
- **Timeout:** a counter of width clog2(TIMEOUT+1) counts cycles with `mem_valid`=1 and `mem_ready`=0. It clears on every transfer and on every phase change. When it reaches `TIMEOUT` (and `TIMEOUT`≠0), `mem_valid` drops, `error`=2, the phase is aborted and the block goes to IDLE.
- **Reset mid-transaction:** `mem_valid` drops asynchronously and all state returns to INIT. Partial results are discarded.
- **Stable outputs:** `inst_rdata` and `data_rdata` change only at their own transfer; they hold value otherwise, including on error.

## Timing
- All outputs are registered. A command accepted at edge N gives `ready`=0 and `mem_valid`=1 from edge N+1.
- With `mem_ready` tied to 1:
  - Fetch-only: `ready` returns at N+2.
  - Read+fetch or write+fetch: `ready` returns at N+3.
  - Illegal command: `ready` stays 1 and `error`=3 from N+1.
- Each `mem_ready` wait cycle adds one cycle. Transfer and the DATA→FETCH transition happen on the same edge; there is no bubble between phases.
- `error` and the read-data outputs are valid from the same edge on which `ready` rises.
- After reset release, `ready`/`mem_start_ready` rise `INIT_CYCLES` edges after the first edge with `rst_n`=1.

## Test plan
- **Reset/INIT:** `INIT_CYCLES`=16, `rst_n` released → `ready`=0 and `mem_start_ready`=0 for 16 edges, then both 1; all other outputs 0.
- **Read+fetch:** `mem_ready`=1, cmd 3, data_addr=0x103, inst_addr=0x200 →
  - DATA: `mem_addr`=0x100, rdata 0xAAAA5555 into `data_rdata`.
  - FETCH: `mem_addr`=0x200, 0x12345678 into `inst_rdata`.
  - `ready` back 3 edges after accept; `error`=0.
- **Write with stalls:** cmd 2, wstrb=0x3, wdata=0xDEADBEEF, `mem_ready` low for 4 cycles → `mem_we`=1 and payload stable throughout, then FETCH. `ready` after 7 edges.
- **Zero strobe:** cmd 2 with wstrb=0 → no write request; only a fetch is issued; `ready` after 2 edges.
- **Errors:**
  - `mem_err`=1 on the read phase → no fetch, `error`=1, `inst_rdata` unchanged.
  - cmd 5 → `error`=3, no `mem_valid`.
  - Next good command → `error` cleared to 0.
- **Timeout and async reset:**
  - `TIMEOUT`=8, `mem_ready` held 0 → `mem_valid` drops after 8 cycles, `error`=2, `ready`=1.
  - `rst_n` pulsed low during FETCH → `mem_valid` 0 immediately; the INIT sequence repeats.
